// File: rtl/cell_pos_pkg.sv
// -----------------------------------------------------------------------------
// cell_pos_pkg
// Shared definitions for the double-buffered cell position memory:
//   - cell_pos_state_t : bank-swap FSM states (IDLE, DRAIN, SWAP)
//   - RD_LAT           : read latency in cycles (bank read + output mux)
//   - CNT_ADDR         : address that returns the particle count instead of a record
// -----------------------------------------------------------------------------
package cell_pos_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } cell_pos_state_t;

  localparam int RD_LAT   = 2;
  localparam int CNT_ADDR = 0;

endpackage

// File: rtl/cell_pos_ram.sv
// -----------------------------------------------------------------------------
// cell_pos_ram
// Simple dual-port RAM, DATA_WIDTH x DEPTH: one synchronous write port and one
// read port with a registered output. A non-empty INIT_FILE attaches a RAM
// init attribute to the array so the vendor flow preloads it.
//
// Ports:
//   clock      in   sole clock
//   wr_en_i    in   write strobe
//   wr_addr_i  in   write address
//   wr_data_i  in   write data
//   rd_en_i    in   read strobe; rd_data_o updates on the next edge
//   rd_addr_i  in   read address
//   rd_data_o  out  registered read data
// -----------------------------------------------------------------------------
module cell_pos_ram #(
  parameter int    DATA_WIDTH = 96,
  parameter int    DEPTH      = 220,
  parameter int    ADDR_WIDTH = 8,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clock,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] rd_data_q;

  // NOTE: the array has no reset; a reset loop over every word would prevent
  // block-RAM inference. Stale words are masked by the particle count instead.
  if (INIT_FILE != "") begin : g_init
    (* ram_init_file = INIT_FILE *)
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
      if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
      if (rd_en_i) rd_data_q <= mem[rd_addr_i];
    end
  end else begin : g_plain
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
      if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
      if (rd_en_i) rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cell_pos_bank.sv
// -----------------------------------------------------------------------------
// cell_pos_bank
// Double-buffered particle position memory for one cell. Force evaluation
// reads the active bank; motion update appends next-step records into the
// shadow bank; a swap handshake exchanges the banks between timesteps.
// Address 0 reads the active particle count, addresses 1..count read
// {posz, posy, posx}, higher addresses read zero.
//
// Build option: define POS_CELL_INIT_EN to preload bank 0 from INIT_FILE and
// reset active_count to INIT_COUNT. Without it, both banks start empty.
//
// Ports:
//   clock         in   sole clock
//   rst           in   synchronous, active-high reset
//   rd_en         in   read request (taken when rd_ready)
//   rd_addr       in   read address in the active bank
//   rd_ready      out  read accept (IDLE only)
//   rd_valid      out  read data qualifier, 2 cycles after accept
//   rd_data       out  read result
//   wr_en         in   append request into the shadow bank
//   wr_data       in   record to append
//   wr_ready      out  append accept
//   swap_req      in   single-cycle bank exchange request
//   swap_ack      out  one-cycle pulse in the swap cycle
//   active_bank   out  bank currently read
//   active_count  out  particle count of the active bank
//   shadow_count  out  particle count of the shadow bank
//   overflow      out  sticky: append attempted while the shadow bank was full
// -----------------------------------------------------------------------------
module cell_pos_bank
  import cell_pos_pkg::*;
#(
  parameter int    DATA_WIDTH   = 96,
  parameter int    PARTICLE_NUM = 220,
  parameter int    ADDR_WIDTH   = 8,
  parameter int    INIT_COUNT   = 0,
  parameter string INIT_FILE    = "cell_ini_file.hex"
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  active_bank,
  output logic [ADDR_WIDTH-1:0] active_count,
  output logic [ADDR_WIDTH-1:0] shadow_count,
  output logic                  overflow
);

`ifdef POS_CELL_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] RST_COUNT  = INIT_EN ? ADDR_WIDTH'(INIT_COUNT) : '0;
  localparam logic [ADDR_WIDTH-1:0] FULL_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  cell_pos_state_t       state_q, state_d;
  logic                  active_bank_q, active_bank_d;
  logic [ADDR_WIDTH-1:0] active_count_q, active_count_d;
  logic [ADDR_WIDTH-1:0] shadow_count_q, shadow_count_d;
  logic                  overflow_q, overflow_d;
  logic                  swap_ack_q, swap_ack_d;

  // Read pipeline: bit 0 marks the bank-read stage, bit RD_LAT-1 the output.
  logic [RD_LAT-1:0]     rd_vld_q, rd_vld_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_count_q;
  logic                  s1_bank_q;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                  rd_acc, wr_acc, shadow_full;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] bank0_rd_data, bank1_rd_data;

  assign shadow_full = (shadow_count_q == FULL_COUNT);
  assign rd_ready    = (state_q == IDLE);
  assign wr_ready    = (state_q != SWAP) && (shadow_count_q < FULL_COUNT);
  assign rd_acc      = rd_en & rd_ready;
  assign wr_acc      = wr_en & wr_ready;
  // Slot 0 holds the count, so record n lives at address n.
  assign wr_addr     = shadow_count_q + 1'b1;

  cell_pos_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (PARTICLE_NUM),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_EN ? INIT_FILE : "")
  ) u_bank0 (
    .clock     (clock),
    .wr_en_i   (wr_acc & active_bank_q),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_addr),
    .rd_data_o (bank0_rd_data)
  );

  cell_pos_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (PARTICLE_NUM),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  ("")
  ) u_bank1 (
    .clock     (clock),
    .wr_en_i   (wr_acc & ~active_bank_q),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_addr),
    .rd_data_o (bank1_rd_data)
  );

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    active_bank_d  = active_bank_q;
    active_count_d = active_count_q;
    shadow_count_d = shadow_count_q;
    overflow_d     = overflow_q;

    case (state_q)
      IDLE:    if (swap_req) state_d = DRAIN;
      // Issue is blocked in DRAIN, so an empty bank-read stage means the
      // last in-flight read is being presented this cycle.
      DRAIN:   if (!rd_vld_q[0]) state_d = SWAP;
      SWAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (wr_acc) shadow_count_d = shadow_count_q + 1'b1;
    if (wr_en && shadow_full && (state_q != SWAP)) overflow_d = 1'b1;

    if (state_q == SWAP) begin
      active_bank_d  = ~active_bank_q;
      active_count_d = shadow_count_q;
      shadow_count_d = '0;
      overflow_d     = 1'b0;
    end

    swap_ack_d = (state_d == SWAP);
    rd_vld_d   = {rd_vld_q[RD_LAT-2:0], rd_acc};
  end

  // Output mux uses the count and bank captured at issue, so a swap that
  // lands while a read is in flight cannot change its result.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_vld_q[0]) begin
      if (s1_addr_q == ADDR_WIDTH'(CNT_ADDR)) begin
        rd_data_d = DATA_WIDTH'(s1_count_q);
      end else if (s1_addr_q <= s1_count_q) begin
        rd_data_d = s1_bank_q ? bank1_rd_data : bank0_rd_data;
      end else begin
        rd_data_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q        <= IDLE;
      active_bank_q  <= 1'b0;
      active_count_q <= RST_COUNT;
      shadow_count_q <= '0;
      overflow_q     <= 1'b0;
      swap_ack_q     <= 1'b0;
      rd_vld_q       <= '0;
      s1_addr_q      <= '0;
      s1_count_q     <= '0;
      s1_bank_q      <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      active_bank_q  <= active_bank_d;
      active_count_q <= active_count_d;
      shadow_count_q <= shadow_count_d;
      overflow_q     <= overflow_d;
      swap_ack_q     <= swap_ack_d;
      rd_vld_q       <= rd_vld_d;
      rd_data_q      <= rd_data_d;
      if (rd_acc) begin
        s1_addr_q  <= rd_addr;
        s1_count_q <= active_count_q;
        s1_bank_q  <= active_bank_q;
      end
    end
  end

  assign rd_valid     = rd_vld_q[RD_LAT-1];
  assign rd_data      = rd_data_q;
  assign swap_ack     = swap_ack_q;
  assign active_bank  = active_bank_q;
  assign active_count = active_count_q;
  assign shadow_count = shadow_count_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_cell_pos_bank.sv
// -----------------------------------------------------------------------------
// tb_cell_pos_bank
// Self-checking bench for cell_pos_bank. A behavioural model keeps both banks
// as plain arrays plus active/shadow counts; reads, appends and swaps are
// predicted from it. Random record contents and random read addresses.
// -----------------------------------------------------------------------------
module tb_cell_pos_bank;

  localparam int DW       = 96;
  localparam int PN       = 220;
  localparam int AW       = 8;
  localparam int INIT_CNT = 12;
`ifdef POS_CELL_INIT_EN
  localparam int EXP_INIT  = INIT_CNT;
  localparam int RST_READS = 1;
`else
  localparam int EXP_INIT  = 0;
  localparam int RST_READS = 2;
`endif

  logic          clock = 1'b0;
  logic          rst, rd_en, wr_en, swap_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] wr_data;
  logic          rd_ready, rd_valid, wr_ready, swap_ack, active_bank, overflow;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] active_count, shadow_count;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  cell_pos_bank #(
    .DATA_WIDTH   (DW),
    .PARTICLE_NUM (PN),
    .ADDR_WIDTH   (AW),
    .INIT_COUNT   (INIT_CNT),
    .INIT_FILE    ("cell_ini_file.hex")
  ) dut (
    .clock        (clock),
    .rst          (rst),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .swap_req     (swap_req),
    .swap_ack     (swap_ack),
    .active_bank  (active_bank),
    .active_count (active_count),
    .shadow_count (shadow_count),
    .overflow     (overflow)
  );

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [2][PN];
  int            m_active, m_acnt, m_scnt;
  bit            m_ovf;
  logic [AW-1:0] rd_list [32];

  function automatic logic [DW-1:0] m_expect(input int addr);
    if (addr == 0) return DW'(m_acnt);
    if (addr <= m_acnt) return m_mem[m_active][addr];
    return '0;
  endfunction

  function automatic void m_append(input logic [DW-1:0] d);
    if (m_scnt < PN - 1) begin
      m_scnt++;
      m_mem[1 - m_active][m_scnt] = d;
    end else begin
      m_ovf = 1'b1;
    end
  endfunction

  function automatic void m_swap();
    m_active = 1 - m_active;
    m_acnt   = m_scnt;
    m_scnt   = 0;
    m_ovf    = 1'b0;
  endfunction

  function automatic void m_reset();
    m_active = 0;
    m_acnt   = EXP_INIT;
    m_scnt   = 0;
    m_ovf    = 1'b0;
  endfunction

  function automatic logic [DW-1:0] rnd_rec();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- scenario building blocks ----------------
  // Back-to-back reads of rd_list[0..n-1]; each result must appear exactly
  // two cycles after issue, in order.
  task automatic read_burst(input string tag, input int n);
    logic [DW-1:0] exp_q[$];
    for (int c = 0; c <= n; c++) begin
      if (c < n) begin
        rd_en   = 1'b1;
        rd_addr = rd_list[c];
        exp_q.push_back(m_expect(int'(rd_list[c])));
      end else begin
        rd_en = 1'b0;
      end
      tick();
      checks++;
      if (c == 0) begin
        if (rd_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s latency: rd_valid=%b one cycle after issue, required 0", tag, rd_valid);
        end
      end else begin
        if (rd_valid !== 1'b1 || rd_data !== exp_q[0]) begin
          errors++;
          $display("FAIL %s read%0d addr=%0d: valid=%b data=%h, required valid=1 data=%h",
                   tag, c - 1, rd_list[c - 1], rd_valid, rd_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s tail: rd_valid=%b after burst, required 0", tag, rd_valid);
    end
  endtask

  task automatic append_n(input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = rnd_rec();
      if (wr_ready !== (m_scnt < PN - 1)) bad++;
      m_append(wr_data);
      tick();
    end
    wr_en = 1'b0;
    checks++;
    if (bad != 0 || shadow_count !== AW'(m_scnt)) begin
      errors++;
      $display("FAIL append_%0d: wr_ready misses=%0d shadow_count=%0d, required misses=0 shadow_count=%0d",
               n, bad, shadow_count, m_scnt);
    end
  endtask

  // swap_req with an empty read pipeline: DRAIN at +1, SWAP/ack at +2,
  // new bank visible at +3. Optionally appends in the request cycle.
  task automatic swap_and_check(input string tag, input bit with_wr, input logic [DW-1:0] d);
    swap_req = 1'b1;
    wr_en    = with_wr;
    wr_data  = d;
    if (with_wr) m_append(d);
    tick();
    swap_req = 1'b0;
    wr_en    = 1'b0;
    checks++;
    if (swap_ack !== 1'b0 || rd_ready !== 1'b0 || overflow !== m_ovf) begin
      errors++;
      $display("FAIL %s drain: ack=%b rd_ready=%b overflow=%b, required ack=0 rd_ready=0 overflow=%b",
               tag, swap_ack, rd_ready, overflow, m_ovf);
    end
    tick();
    checks++;
    if (swap_ack !== 1'b1 || rd_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s swap: ack=%b rd_ready=%b, required ack=1 rd_ready=0", tag, swap_ack, rd_ready);
    end
    m_swap();
    tick();
    checks++;
    if (swap_ack !== 1'b0 || rd_ready !== 1'b1 || active_bank !== m_active[0] ||
        active_count !== AW'(m_acnt) || shadow_count !== 0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL %s after: ack=%b rdy=%b bank=%b acnt=%0d scnt=%0d ovf=%b, required 0 1 %0d %0d 0 0",
               tag, swap_ack, rd_ready, active_bank, active_count, shadow_count, overflow,
               m_active, m_acnt);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
    rd_addr = '0; wr_data = '0;
    tick();
    tick();
    rst = 1'b0;
    m_reset();
    checks++;
    if (active_bank !== 1'b0 || active_count !== AW'(EXP_INIT) || shadow_count !== 0 ||
        overflow !== 1'b0 || rd_valid !== 1'b0 || rd_data !== '0 || swap_ack !== 1'b0 ||
        rd_ready !== 1'b1 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: bank=%b acnt=%0d scnt=%0d ovf=%b vld=%b data=%h ack=%b rrdy=%b wrdy=%b, required acnt=%0d rest idle",
               active_bank, active_count, shadow_count, overflow, rd_valid, rd_data, swap_ack,
               rd_ready, wr_ready, EXP_INIT);
    end
    rd_list[0] = 8'd0;
    rd_list[1] = 8'd1;
    read_burst("reset_reads", RST_READS);
  endtask

  task automatic test_append_swap();
    append_n(3);
    swap_and_check("swap3", 1'b0, '0);
    for (int i = 0; i < 5; i++) rd_list[i] = AW'(i);
    read_burst("seq_reads", 5);
    for (int i = 0; i < 12; i++) rd_list[i] = AW'($urandom_range(0, 7));
    read_burst("rand_reads", 12);
  endtask

  task automatic test_read_during_swap();
    logic [DW-1:0] e1, e2;
    append_n(2);
    rd_en   = 1'b1;
    rd_addr = 8'd1;
    e1      = m_expect(1);
    checks++;
    if (rd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rds_issue: rd_ready=%b, required 1", rd_ready);
    end
    tick();
    rd_addr  = 8'd2;
    e2       = m_expect(2);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    rd_addr  = 8'd3;
    checks++;
    if (rd_ready !== 1'b0 || rd_valid !== 1'b1 || rd_data !== e1 || swap_ack !== 1'b0) begin
      errors++;
      $display("FAIL rds_t2: rdy=%b vld=%b data=%h ack=%b, required 0 1 %h 0",
               rd_ready, rd_valid, rd_data, swap_ack, e1);
    end
    tick();
    checks++;
    if (rd_ready !== 1'b0 || rd_valid !== 1'b1 || rd_data !== e2 || swap_ack !== 1'b0) begin
      errors++;
      $display("FAIL rds_t3: rdy=%b vld=%b data=%h ack=%b, required 0 1 %h 0",
               rd_ready, rd_valid, rd_data, swap_ack, e2);
    end
    tick();
    rd_en = 1'b0;
    checks++;
    if (swap_ack !== 1'b1 || rd_valid !== 1'b0 || rd_ready !== 1'b0) begin
      errors++;
      $display("FAIL rds_t4: ack=%b vld=%b rdy=%b, required 1 0 0", swap_ack, rd_valid, rd_ready);
    end
    m_swap();
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_ready !== 1'b1 || swap_ack !== 1'b0 ||
        active_bank !== m_active[0] || active_count !== AW'(m_acnt)) begin
      errors++;
      $display("FAIL rds_t5: vld=%b rdy=%b ack=%b bank=%b acnt=%0d, required 0 1 0 %0d %0d",
               rd_valid, rd_ready, swap_ack, active_bank, active_count, m_active, m_acnt);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rds_t6: rd_valid=%b from an ignored read, required 0", rd_valid);
    end
  endtask

  task automatic test_overflow();
    append_n(PN - 1);
    checks++;
    if (wr_ready !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full: wr_ready=%b overflow=%b, required 0 0", wr_ready, overflow);
    end
    wr_en   = 1'b1;
    wr_data = rnd_rec();
    m_append(wr_data);
    tick();
    wr_en = 1'b0;
    checks++;
    if (overflow !== 1'b1 || shadow_count !== AW'(PN - 1)) begin
      errors++;
      $display("FAIL overflow: overflow=%b shadow_count=%0d, required 1 %0d",
               overflow, shadow_count, PN - 1);
    end
    swap_and_check("swap_full", 1'b0, '0);
    rd_list[0] = 8'd0;   rd_list[1] = 8'd1;   rd_list[2] = 8'd218;
    rd_list[3] = 8'd219; rd_list[4] = 8'd220; rd_list[5] = 8'd255;
    for (int i = 6; i < 20; i++) rd_list[i] = AW'($urandom_range(0, 255));
    read_burst("full_reads", 20);
  endtask

  task automatic test_wr_and_swap();
    logic [DW-1:0] x;
    append_n(5);
    x = rnd_rec();
    swap_and_check("wr_swap", 1'b1, x);
    rd_list[0] = 8'd6;
    rd_list[1] = 8'd7;
    rd_list[2] = 8'd0;
    read_burst("wr_swap_reads", 3);
  endtask

  task automatic test_reset_mid_swap();
    append_n(1);
    swap_and_check("pre_rst_swap", 1'b0, '0);
    append_n(1);
    rd_en    = 1'b1;
    rd_addr  = 8'd1;
    swap_req = 1'b1;
    tick();
    rd_en    = 1'b0;
    swap_req = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    m_reset();
    checks++;
    if (rd_valid !== 1'b0 || swap_ack !== 1'b0 || active_bank !== 1'b0 ||
        active_count !== AW'(EXP_INIT) || shadow_count !== 0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_drain: vld=%b ack=%b bank=%b acnt=%0d scnt=%0d ovf=%b, required 0 0 0 %0d 0 0",
               rd_valid, swap_ack, active_bank, active_count, shadow_count, overflow, EXP_INIT);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || swap_ack !== 1'b0 || rd_ready !== 1'b1 || active_bank !== 1'b0) begin
      errors++;
      $display("FAIL rst_after: vld=%b ack=%b rdy=%b bank=%b, required 0 0 1 0",
               rd_valid, swap_ack, rd_ready, active_bank);
    end
    rd_list[0] = 8'd0;
    read_burst("rst_count", 1);
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
    rd_addr = '0; wr_data = '0;
    test_reset();
    test_append_swap();
    test_read_during_swap();
    test_overflow();
    test_wr_and_swap();
    test_reset_mid_swap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
